conv_enc_k3: RTL and testbench
==============================

# conv_enc_k3

Frame-based rate-1/2 convolutional encoder (K=3, G0=7, G1=5, LSB insertion) sitting directly upstream of the Viterbi decoder. It accepts a frame of information bits over a valid/ready bit interface and emits 2-bit coded symbols over a valid/ready symbol interface. A two-entry output FIFO decouples it from the decoder's `rx_ready` backpressure. Optional tail bits return the trellis to state 0 at end of frame.

## Interface
- `MAX_BITS`, default 32: maximum information bits per frame. This matches the decoder frame size.
- `LEN_W`, default 6: width of `frame_len`. Must satisfy `2^LEN_W > MAX_BITS`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that opens a frame. Ignored while `busy`.
- `frame_len` in LEN_W: information bits in the frame, sampled on an accepted `start`.
- `in_valid` in 1: `in_bit` is valid.
- `in_bit` in 1: information bit, transmitted bit 0 of the pattern first.
- `in_ready` out 1: encoder accepts a bit this cycle.
- `sym_valid` out 1: FIFO head is valid.
- `sym` out 2: `{G0 output, G1 output}`, MSB is G0.
- `sym_ready` in 1: consumer takes the FIFO head this cycle.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse when the frame's last symbol is popped.

## Operation
- **Encoder state** is a 2-bit register `st`.
  - For input `b`, form `r = {st, b}`.
  - `sym[1] = r[2]^r[1]^r[0]` (G0=7).
  - `sym[0] = r[2]^r[0]` (G1=5).
  - Then `st <= {st[0], b}`.
- **FSM states:** IDLE, DATA, TAIL, DRAIN.
  - IDLE: on `start`, latch `len = min(frame_len, MAX_BITS)`, clear `st` and the bit counter, and go to DATA.
  - DATA: a bit is accepted when `in_valid & in_ready`. The bit is encoded, its symbol is pushed to the FIFO, and the counter is incremented. After the `len`-th accept, go to TAIL (macro defined) or DRAIN (macro undefined).
  - TAIL: push two symbols for `b=0`, one per cycle, each only when the FIFO is not full. Then go to DRAIN.
  - DRAIN: wait for the FIFO to empty. In that cycle pulse `frame_done` and go to IDLE.
- **Zero-length frame:** if `len == 0`, DATA is skipped and the FSM goes straight to TAIL or DRAIN.
- **`in_ready`** = (state==DATA) & (fifo_count<2).
  - It depends only on registered state, with no combinational path from `sym_ready`.
  - Bits presented outside DATA are neither consumed nor encoded.
- **FIFO** is 2 entries, first-word-fall-through.
  - `sym_valid` = (count!=0).
  - `sym` = head entry, registered.
  - A push and a pop in the same cycle leave the count unchanged and preserve order.
- **`busy`** = (state!=IDLE).
- **Reset mid-frame** discards the frame, empties the FIFO, and clears `st`. No `frame_done` is produced.

## Timing
- **Reset values:** `in_ready`=0, `sym_valid`=0, `sym`=2'b00, `busy`=0, `frame_done`=0, `st`=0, FSM=IDLE.
- `start` accepted at edge N: `busy`=1 and `in_ready`=1 after edge N.
- Bit accepted at edge N: its symbol is visible on `sym` with `sym_valid`=1 after edge N, a latency of 1 cycle.
- **Throughput:** with `sym_ready` held high, one bit per cycle.
- **Backpressure:** with `sym_ready`=0, exactly two bits are accepted, then `in_ready` drops.
- **`frame_done`:** asserted in the cycle after the edge on which the final pop empties the FIFO. It lasts one cycle, and `busy` falls in the same cycle.
- A new `start` is accepted from the cycle `busy`=0 onward.

## Configuration
- `CONV_TAIL_FLUSH_EN` defined:
  - Every frame appends 2 zero-input tail symbols after the data symbols.
  - Output length is `len+2` symbols.
  - `st`=0 at `frame_done`.
- `CONV_TAIL_FLUSH_EN` undefined:
  - The TAIL state is absent and no tail symbols are emitted.
  - Output length is exactly `len` symbols, matching the decoder's unterminated-frame mode.

## Test plan
- **Pattern 8'b10110100, bits fed LSB first (0,0,1,0,1,1,0,1), `sym_ready`=1:**
  - Symbols must be 00,00,11,10,00,01,01,00.
  - With `CONV_TAIL_FLUSH_EN`, these are followed by 10,11.
  - `frame_done` fires once.
- **All-ones, `frame_len`=4:**
  - Symbols must be 11,01,10,10.
  - With the tail: then 01,11.
- **Backpressure:** `sym_ready`=0 with `in_valid`=1 held.
  - `in_ready` deasserts after 2 accepts.
  - Releasing `sym_ready` drains the symbols in order with no loss or duplication.
- **`frame_len`=0:**
  - Without the macro: `frame_done` with zero symbols.
  - With the macro: exactly 00,00, then `frame_done`.
- **`frame_len`=40 (>MAX_BITS):** clamped, so exactly 32 bits are accepted and `in_ready` stays 0 thereafter.
- **`rst_n` pulsed low mid-frame after 5 bits:**
  - All outputs return to reset values immediately.
  - No `frame_done` is produced.
  - A following 8-bit frame encodes from `st`=0 correctly.

Source files
------------

// File: rtl/conv_enc_k3.sv
// conv_enc_k3: frame-based rate-1/2 convolutional encoder, K=3, G0=7, G1=5.
// Bits come in over a valid/ready interface. 2-bit symbols {G0,G1} leave
// through a 2-entry first-word-fall-through FIFO.
// Optional feature: define CONV_TAIL_FLUSH_EN to append two zero-input tail
// symbols per frame, which returns the trellis to state 0.
module conv_enc_k3 #(
  parameter int MAX_BITS = 32,
  parameter int LEN_W    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             sym_valid,
  output logic [1:0]       sym,
  input  logic             sym_ready,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;

`ifdef CONV_TAIL_FLUSH_EN
  localparam state_t AFTER_DATA = TAIL;
`else
  localparam state_t AFTER_DATA = DRAIN;
`endif

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);

  state_t           state, state_nxt;
  logic [1:0]       st, st_nxt;
  logic [LEN_W-1:0] len_q, len_nxt, len_clamp;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic             done_nxt;
  logic             push, pop, enc_b;
  logic [1:0]       enc_sym;
  logic [1:0]       fcnt, fcnt_nxt;
  logic [1:0]       mem0, mem1, mem0_nxt, mem1_nxt;
`ifdef CONV_TAIL_FLUSH_EN
  logic             tail_q, tail_nxt;
`endif

  // The outputs depend only on registered state, so there is no path from sym_ready to in_ready.
  assign in_ready  = (state == DATA) && (fcnt != 2'd2);
  assign sym_valid = (fcnt != 2'd0);
  assign sym       = mem0;
  assign busy      = (state != IDLE);
  assign pop       = sym_valid && sym_ready;
  assign len_clamp = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
  // r = {st, b}: G0 = r2^r1^r0, G1 = r2^r0
  assign enc_sym   = {st[1] ^ st[0] ^ enc_b, st[1] ^ enc_b};

  // FSM next state and encoder control. The encoder input is forced to zero in TAIL.
  always_comb begin
    state_nxt = state;
    st_nxt    = st;
    len_nxt   = len_q;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    push      = 1'b0;
    enc_b     = in_bit;
`ifdef CONV_TAIL_FLUSH_EN
    tail_nxt  = tail_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          len_nxt   = len_clamp;
          cnt_nxt   = '0;
          st_nxt    = 2'b00;
`ifdef CONV_TAIL_FLUSH_EN
          tail_nxt  = 1'b0;
`endif
          state_nxt = (len_clamp == '0) ? AFTER_DATA : DATA;
        end
      end
      DATA: begin
        if (in_valid && in_ready) begin
          push    = 1'b1;
          st_nxt  = {st[0], in_bit};
          cnt_nxt = cnt + LEN_W'(1);
          if (cnt_nxt == len_q) state_nxt = AFTER_DATA;
        end
      end
`ifdef CONV_TAIL_FLUSH_EN
      TAIL: begin
        enc_b = 1'b0;
        if (fcnt != 2'd2) begin
          push     = 1'b1;
          st_nxt   = {st[0], 1'b0};
          tail_nxt = 1'b1;
          if (tail_q) state_nxt = DRAIN;
        end
      end
`endif
      DRAIN: begin
        // Nothing is pushed in DRAIN, so the FIFO becomes empty when it holds one entry that is popped now.
        if (fcnt == 2'd0 || (fcnt == 2'd1 && pop)) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO next state. mem0 is always the head. A push and a pop together keep order.
  always_comb begin
    fcnt_nxt = fcnt;
    mem0_nxt = mem0;
    mem1_nxt = mem1;
    case ({push, pop})
      2'b10: begin
        if (fcnt == 2'd0) mem0_nxt = enc_sym;
        else              mem1_nxt = enc_sym;
        fcnt_nxt = fcnt + 2'd1;
      end
      2'b01: begin
        mem0_nxt = mem1;
        fcnt_nxt = fcnt - 2'd1;
      end
      2'b11: begin
        if (fcnt == 2'd1) begin
          mem0_nxt = enc_sym;
        end else begin
          mem0_nxt = mem1;
          mem1_nxt = enc_sym;
        end
      end
      default: ;
    endcase
  end

  // State registers. Reset discards any frame in flight and produces no frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      st         <= 2'b00;
      len_q      <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
      fcnt       <= 2'd0;
      mem0       <= 2'b00;
      mem1       <= 2'b00;
`ifdef CONV_TAIL_FLUSH_EN
      tail_q     <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      st         <= st_nxt;
      len_q      <= len_nxt;
      cnt        <= cnt_nxt;
      frame_done <= done_nxt;
      fcnt       <= fcnt_nxt;
      mem0       <= mem0_nxt;
      mem1       <= mem1_nxt;
`ifdef CONV_TAIL_FLUSH_EN
      tail_q     <= tail_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_conv_enc_k3.sv
// Testbench for conv_enc_k3. It runs table vectors from the worked examples,
// then backpressure, clamp and randomized frames checked against a
// convolution model, then a mid-frame reset.
module tb_conv_enc_k3;
  localparam int MAX_BITS = 32;
  localparam int LEN_W    = 6;
`ifdef CONV_TAIL_FLUSH_EN
  localparam int NT = 2;
`else
  localparam int NT = 0;
`endif

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             start = 1'b0, in_valid = 1'b0, in_bit = 1'b0, sym_ready = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic             in_ready, sym_valid, busy, frame_done;
  logic [1:0]       sym;

  conv_enc_k3 #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  typedef logic [1:0] sq_t[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Direct convolution over the bit sequence: out_i uses b[i], b[i-1], b[i-2].
  // Bits outside 0..n-1 are zero, which also produces the zero-input tail.
  function automatic sq_t model(input int len, input logic [63:0] bits);
    sq_t q;
    int  n = (len > MAX_BITS) ? MAX_BITS : len;
    for (int i = 0; i < n + NT; i++) begin
      bit b0, b1, b2;
      b0 = (i < n) ? bits[i] : 1'b0;
      b1 = (i >= 1 && i - 1 < n) ? bits[i-1] : 1'b0;
      b2 = (i >= 2 && i - 2 < n) ? bits[i-2] : 1'b0;
      q.push_back({b0 ^ b1 ^ b2, b0 ^ b2});
    end
    return q;
  endfunction

  // rmode: 0 = sym_ready high, 1 = random, 2 = low for 6 cycles then high.
  task automatic run_frame(input string tag, input int len, input logic [63:0] bits,
                           input sq_t exp, input int rmode, input bit vrand);
    sq_t got;
    int  acc = 0, dones = 0, cyc = 0, n;
    bit  over = 0, prev_acc = 0;
    n = (len > MAX_BITS) ? MAX_BITS : len;
    @(negedge clk);
    start = 1'b1; frame_len = LEN_W'(len); in_valid = 1'b0; sym_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_after_start"}, busy, 1);
    chk({tag, " in_ready_after_start"}, in_ready, (n > 0) ? 1 : 0);
    while (dones == 0 && cyc < 2000) begin
      if (frame_done) begin
        dones++;
        chk({tag, " busy_at_done"}, busy, 0);
      end else begin
        if (rmode == 0 && prev_acc) chk({tag, " latency"}, sym_valid, 1);
        in_valid  = vrand ? 1'($urandom % 2) : 1'b1;
        in_bit    = (acc < 64) ? bits[acc] : 1'b0;
        sym_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom % 2) : (cyc >= 6);
        #1;
        if (rmode == 2 && cyc == 6) begin
          chk({tag, " bp_accepts"}, acc, 2);
          chk({tag, " bp_in_ready"}, in_ready, 0);
        end
        prev_acc = in_valid && in_ready;
        if (in_valid && in_ready) begin
          if (acc >= n) over = 1;
          acc++;
        end
        if (sym_valid && sym_ready) got.push_back(sym);
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, " done_seen"}, dones, 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, " done_one_cycle"}, frame_done, 0);
    chk({tag, " accepted"}, acc, n);
    chk({tag, " no_over_accept"}, over, 0);
    chk({tag, " sym_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s sym[%0d]", tag, i), (i < got.size()) ? got[i] : 2'bxx, exp[i]);
  endtask

  typedef struct {
    int          len;
    logic [63:0] bits;
    logic [15:0] data;  // symbol i at [2i+1:2i]
    logic [3:0]  tail;  // tail symbols, first at [1:0]
  } vec_t;

  initial begin
    vec_t        tbl[4];
    sq_t         q;
    logic [63:0] rb;
    int          acc, dones;

    tbl[0] = '{len: 8, bits: 64'hB4, data: 16'h14B0, tail: 4'hE};
    tbl[1] = '{len: 4, bits: 64'hF,  data: 16'h00A7, tail: 4'hD};
    tbl[2] = '{len: 0, bits: 64'h0,  data: 16'h0000, tail: 4'h0};
    tbl[3] = '{len: 1, bits: 64'h1,  data: 16'h0003, tail: 4'hE};

    repeat (2) @(negedge clk);
    chk("rst in_ready", in_ready, 0);
    chk("rst sym_valid", sym_valid, 0);
    chk("rst sym", sym, 0);
    chk("rst busy", busy, 0);
    chk("rst frame_done", frame_done, 0);
    rst_n = 1'b1;

    for (int t = 0; t < 4; t++) begin
      q = {};
      for (int i = 0; i < tbl[t].len; i++) q.push_back(tbl[t].data[2*i +: 2]);
      for (int i = 0; i < NT; i++) q.push_back(tbl[t].tail[2*i +: 2]);
      run_frame($sformatf("vec%0d", t), tbl[t].len, tbl[t].bits, q, 0, 0);
    end

    rb = {$urandom, $urandom};
    run_frame("bp", 8, rb, model(8, rb), 2, 0);
    rb = {$urandom, $urandom};
    run_frame("clamp", 40, rb, model(40, rb), 0, 0);
    for (int f = 0; f < 6; f++) begin
      int l;
      l  = $urandom_range(0, 40);
      rb = {$urandom, $urandom};
      run_frame($sformatf("rnd%0d", f), l, rb, model(l, rb), 1, 1);
    end

    // Abort a frame after 5 accepted bits using an asynchronous reset.
    rb = {$urandom, $urandom};
    acc = 0; dones = 0;
    @(negedge clk);
    start = 1'b1; frame_len = LEN_W'(8); sym_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 50 && acc < 5; c++) begin
      in_valid = 1'b1; in_bit = rb[acc];
      #1;
      if (in_ready) acc++;
      @(negedge clk);
      if (frame_done) dones++;
    end
    in_valid = 1'b0;
    chk("abort accepted", acc, 5);
    rst_n = 1'b0;
    #1;
    chk("abort in_ready", in_ready, 0);
    chk("abort sym_valid", sym_valid, 0);
    chk("abort sym", sym, 0);
    chk("abort busy", busy, 0);
    chk("abort frame_done", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if (frame_done) dones++;
    chk("abort no_done", dones, 0);
    run_frame("post_rst", 8, 64'hB4, model(8, 64'hB4), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
